// File: rtl/als_display_driver_if.sv
// als_display_driver_if
//   Groups the light-value input with the BCD result and display outputs of
//   als_display_driver.
//   Signals:
//     value     [7:0]  unsigned light value, held between frames (no strobe)
//     bcd       [11:0] {hundreds, tens, ones} BCD result
//     bcd_valid        one-cycle pulse when bcd updates
//     anode     [3:0]  digit enables, active low, bit 0 = rightmost digit
//     segment   [6:0]  segments {g,f,e,d,c,b,a}, active low
//   Modports:
//     master : the ALS side / consumer (drives value, observes results)
//     slave  : the display driver itself
interface als_display_driver_if;
  logic [7:0]  value;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic [3:0]  anode;
  logic [6:0]  segment;

  modport master (
    output value,
    input  bcd,
    input  bcd_valid,
    input  anode,
    input  segment
  );

  modport slave (
    input  value,
    output bcd,
    output bcd_valid,
    output anode,
    output segment
  );
endinterface

// File: rtl/als_display_driver.sv
// als_display_driver
//   Periodically samples the held ambient-light value, converts it to three
//   BCD digits with a sequential double-dabble engine (one iteration per
//   clock) and drives a 4-digit common-anode multiplexed 7-segment display
//   with leading-zero blanking. The BCD result is also exported with a
//   one-cycle valid strobe.
//   Ports:
//     i_system_clock  system clock, rising edge
//     i_reset         synchronous active-high reset
//     bus             als_display_driver_if.slave (value in; bcd, bcd_valid,
//                     anode, segment out)
//   Parameters:
//     SAMPLE_PERIOD   clocks between value samples (>= 10)
//     REFRESH_PERIOD  clocks each digit stays lit per scan step (>= 1)
module als_display_driver #(
  parameter int unsigned SAMPLE_PERIOD  = 32'd1000000,
  parameter int unsigned REFRESH_PERIOD = 32'd100000
) (
  input  logic                 i_system_clock,
  input  logic                 i_reset,
  als_display_driver_if.slave  bus
);

  localparam int unsigned SW = (SAMPLE_PERIOD  > 32'd1) ? $clog2(SAMPLE_PERIOD)  : 32'd1;
  localparam int unsigned RW = (REFRESH_PERIOD > 32'd1) ? $clog2(REFRESH_PERIOD) : 32'd1;
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_PERIOD  - 32'd1);
  localparam logic [RW-1:0] SCAN_LAST   = RW'(REFRESH_PERIOD - 32'd1);
  localparam logic [6:0]    SEG_BLANK   = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // One double-dabble iteration on {hundreds, tens, ones, binary}:
  // add 3 to every BCD nibble >= 5, then shift the whole register left.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] a;
    a = v;
    for (int n = 0; n < 3; n++) begin
      if (a[8 + 4*n +: 4] >= 4'd5) begin
        a[8 + 4*n +: 4] = a[8 + 4*n +: 4] + 4'd3;
      end else begin
        a[8 + 4*n +: 4] = a[8 + 4*n +: 4];
      end
    end
    return {a[18:0], 1'b0};
  endfunction

  // Active-low gfedcba pattern for one decimal digit; out-of-range is blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [SW-1:0] sample_cnt_r;
  logic [RW-1:0] scan_cnt_r;
  logic [1:0]    digit_r;
  state_t        state_r;
  logic [19:0]   shift_r;
  logic [2:0]    iter_r;
  logic [11:0]   bcd_r;
  logic          valid_r;

  logic          tick_s;
  state_t        state_nx_s;
  logic [19:0]   shift_nx_s;
  logic [2:0]    iter_nx_s;
  logic [11:0]   bcd_nx_s;
  logic          valid_nx_s;
  logic [3:0]    anode_s;
  logic [6:0]    segment_s;

  assign tick_s = (sample_cnt_r == SAMPLE_LAST);

  // Free-running sample counter; wraps at SAMPLE_PERIOD-1 regardless of FSM state.
  always_ff @(posedge i_system_clock) begin
    if (i_reset) begin
      sample_cnt_r <= {SW{1'b0}};
    end else if (tick_s) begin
      sample_cnt_r <= {SW{1'b0}};
    end else begin
      sample_cnt_r <= sample_cnt_r + SW'(1'b1);
    end
  end

  // Display scan: dwell counter and digit index advancing 0,1,2,3,0,...
  always_ff @(posedge i_system_clock) begin
    if (i_reset) begin
      scan_cnt_r <= {RW{1'b0}};
      digit_r    <= 2'd0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= {RW{1'b0}};
      digit_r    <= digit_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + RW'(1'b1);
      digit_r    <= digit_r;
    end
  end

  // Conversion FSM state register.
  always_ff @(posedge i_system_clock) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Conversion datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge i_system_clock) begin
    if (i_reset) begin
      shift_r <= 20'h00000;
      iter_r  <= 3'd0;
      bcd_r   <= 12'h000;
      valid_r <= 1'b0;
    end else begin
      shift_r <= shift_nx_s;
      iter_r  <= iter_nx_s;
      bcd_r   <= bcd_nx_s;
      valid_r <= valid_nx_s;
    end
  end

  // Next-state and datapath logic; ticks outside IDLE are dropped, not queued.
  always_comb begin
    state_nx_s = state_r;
    shift_nx_s = shift_r;
    iter_nx_s  = iter_r;
    bcd_nx_s   = bcd_r;
    valid_nx_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_nx_s = ST_CONVERT;
          shift_nx_s = {12'h000, bus.value};
          iter_nx_s  = 3'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        shift_nx_s = dd_step(shift_r);
        iter_nx_s  = iter_r + 3'd1;
        if (iter_r == 3'd7) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_CONVERT;
        end
      end
      ST_DONE: begin
        bcd_nx_s   = shift_r[19:8];
        valid_nx_s = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Anode drive: all digits off except the one currently scanned.
  always_comb begin
    anode_s          = 4'b1111;
    anode_s[digit_r] = 1'b0;
  end

  // Segment select with leading-zero blanking; an interior zero (e.g. 105) stays lit.
  always_comb begin
    segment_s = SEG_BLANK;
    case (digit_r)
      2'd0: begin
        segment_s = seg7(bcd_r[3:0]);
      end
      2'd1: begin
        if ((bcd_r[11:8] == 4'd0) && (bcd_r[7:4] == 4'd0)) begin
          segment_s = SEG_BLANK;
        end else begin
          segment_s = seg7(bcd_r[7:4]);
        end
      end
      2'd2: begin
        if (bcd_r[11:8] == 4'd0) begin
          segment_s = SEG_BLANK;
        end else begin
          segment_s = seg7(bcd_r[11:8]);
        end
      end
      2'd3: begin
        segment_s = SEG_BLANK;
      end
      default: begin
        segment_s = SEG_BLANK;
      end
    endcase
  end

  assign bus.bcd       = bcd_r;
  assign bus.bcd_valid = valid_r;
  assign bus.anode     = anode_s;
  assign bus.segment   = segment_s;

endmodule

// File: tb/tb_als_display_driver.sv
// tb_als_display_driver
//   Directed bench for als_display_driver with SAMPLE_PERIOD=16 and
//   REFRESH_PERIOD=4. Expected BCD results are queued with the cycle they
//   must appear in; a negedge monitor pops and compares every valid pulse.
//   Display scans are compared against hand-written segment patterns.
module tb_als_display_driver;

  typedef struct {
    logic [11:0] bcd;
    int          at;
  } exp_t;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SB = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  int   cyc;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  als_display_driver_if bus ();

  als_display_driver #(
    .SAMPLE_PERIOD (16),
    .REFRESH_PERIOD(4)
  ) dut (
    .i_system_clock(clk),
    .i_reset       (rst),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset edge (cycle 0 = first cycle after reset).
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Scoreboard monitor: every valid pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.bcd_valid === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL valid_unexpected: got bcd=%h at cycle %0d, required no pulse", bus.bcd, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.bcd !== mon_e.bcd || cyc != mon_e.at) begin
          bad++;
          $display("FAIL bcd_pulse: got bcd=%h at cycle %0d, required bcd=%h at cycle %0d",
                   bus.bcd, cyc, mon_e.bcd, mon_e.at);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_at(input logic [11:0] b, input int at);
    exp_t e;
    e.bcd = b;
    e.at  = at;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, got, req, cyc);
    end
  endtask

  task automatic check_scan(input int s, input int n, input logic [11:0] b,
                            input logic [6:0] d0, input logic [6:0] d1,
                            input logic [6:0] d2, input logic [6:0] d3);
    logic [3:0] an_req;
    logic [6:0] seg_req;
    int         idx;
    for (int i = 0; i < n; i++) begin
      wait_cyc(s + i);
      idx = (cyc / 4) % 4;
      case (idx)
        0:       begin an_req = 4'b1110; seg_req = d0; end
        1:       begin an_req = 4'b1101; seg_req = d1; end
        2:       begin an_req = 4'b1011; seg_req = d2; end
        default: begin an_req = 4'b0111; seg_req = d3; end
      endcase
      chk("scan_anode",   {12'h000, bus.anode},  {12'h000, an_req});
      chk("scan_segment", {9'h000, bus.segment}, {9'h000, seg_req});
      chk("bcd_hold",     {4'h0, bus.bcd},       {4'h0, b});
    end
  endtask

  // Directed stimulus; each value is applied before the tick that samples it.
  initial begin
    rst       = 1'b1;
    bus.value = 8'd255;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset_bcd",     {4'h0, bus.bcd},       16'h0000);
    chk("reset_valid",   {15'h0000, bus.bcd_valid}, 16'h0000);
    chk("reset_anode",   {12'h000, bus.anode},  16'h000E);
    chk("reset_segment", {9'h000, bus.segment}, {9'h000, S0});
    rst = 1'b0;

    expect_at(12'h255, 25);
    wait_cyc(25);
    bus.value = 8'd7;
    expect_at(12'h007, 41);
    check_scan(25, 16, 12'h255, S5, S5, S2, SB);

    wait_cyc(41);
    bus.value = 8'd105;
    expect_at(12'h105, 57);
    check_scan(41, 16, 12'h007, S7, SB, SB, SB);

    wait_cyc(57);
    bus.value = 8'd0;
    expect_at(12'h000, 73);
    check_scan(57, 16, 12'h105, S5, S0, S1, SB);

    wait_cyc(73);
    expect_at(12'h000, 89);
    check_scan(73, 16, 12'h000, S0, SB, SB, SB);

    wait_cyc(89);
    bus.value = 8'd200;
    expect_at(12'h200, 105);
    check_scan(89, 7, 12'h000, S0, SB, SB, SB);
    wait_cyc(96);
    bus.value = 8'd50;
    expect_at(12'h050, 121);
    check_scan(96, 9, 12'h000, S0, SB, SB, SB);

    wait_cyc(105);
    check_scan(105, 16, 12'h200, S0, S0, S2, SB);

    wait_cyc(121);
    bus.value = 8'd99;
    check_scan(121, 10, 12'h050, S0, S5, SB, SB);

    // Tick at 127 loads 99; cycle 131 is the 4th conversion iteration.
    wait_cyc(131);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bcd",     {4'h0, bus.bcd},       16'h0000);
    chk("abort_valid",   {15'h0000, bus.bcd_valid}, 16'h0000);
    chk("abort_anode",   {12'h000, bus.anode},  16'h000E);
    chk("abort_segment", {9'h000, bus.segment}, {9'h000, S0});
    rst = 1'b0;
    expect_at(12'h099, 25);

    wait_cyc(30);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL pulses_missing: got %0d pending, required 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/als_display_driver.md
Name: als_display_driver

Overview:
- Consumer stage for the 8-bit ambient-light value produced by the ALS SPI controller.
- Samples the held light value periodically and converts it to 3 BCD digits with a sequential double-dabble engine, one iteration per clock.
- Drives a 4-digit, common-anode, multiplexed 7-segment display with leading-zero blanking.
- Also exports the BCD result with a one-cycle valid strobe for other consumers.

Parameters:
- SAMPLE_PERIOD, 1000000, clocks between value samples; legal range >= 10.
- REFRESH_PERIOD, 100000, clocks each digit stays lit per scan step; legal range >= 1.

Ports:
- i_system_clock  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_value  input  8  unsigned light value from the ALS controller; held between frames, no strobe.
- o_bcd  output  12  {hundreds, tens, ones}, 4 bits each.
- o_bcd_valid  output  1  one-cycle pulse when o_bcd updates.
- o_anode  output  4  digit enables, active low; bit 0 = rightmost digit.
- o_segment  output  7  segments {g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (i_reset high at a clock edge):
  - Sample counter = 0, scan counter = 0, digit index = 0, FSM = IDLE.
  - o_bcd = 12'h000, o_bcd_valid = 0.
  - Resulting outputs: o_anode = 4'b1110, o_segment = 7'b1000000 (digit "0").
  - Reset mid-conversion aborts the conversion; no o_bcd_valid pulse is produced.
- Sample tick:
  - Counter runs 0..SAMPLE_PERIOD-1 and wraps.
  - Tick is high in the cycle where the counter equals SAMPLE_PERIOD-1.
  - First tick occurs in cycle SAMPLE_PERIOD-1 after reset is released.
  - The counter runs freely regardless of FSM state.
- FSM (2-bit state):
  - IDLE: on tick, load shift register = {12'h000, i_value}, iteration count = 0, go to CONVERT. Without tick, stay in IDLE.
  - CONVERT: each cycle, add 3 to every BCD nibble >= 5, then shift the 20-bit register left by 1. Count 0..7; after the iteration with count == 7, go to DONE.
  - DONE: on the next edge, o_bcd <= BCD nibbles, o_bcd_valid <= 1, go to IDLE.
  - o_bcd_valid is high for exactly one cycle; it is 0 in all other cycles.
  - Ticks arriving in CONVERT or DONE are ignored (never queued).
- Latency and capture:
  - Edge that samples i_value -> o_bcd/o_bcd_valid visible 10 cycles later (1 load + 8 iterations + 1 latch).
  - Changes on i_value after the load edge do not affect the result.
  - o_bcd holds its value between updates.
- Arithmetic: 8-bit binary to 3 BCD digits; max value 255 -> 2,5,5. Hundreds nibble never exceeds 2.
- Scan:
  - Scan counter runs 0..REFRESH_PERIOD-1; at REFRESH_PERIOD-1 it wraps and the digit index increments.
  - Digit index sequence is 0,1,2,3,0,...
  - o_anode = all ones with bit[index] cleared.
  - Scan is independent of the FSM; the display always shows the current o_bcd.
- Segment select (combinational from index and o_bcd; no state):
  - Index 0: ones, always shown.
  - Index 1: tens; blank if hundreds==0 and tens==0.
  - Index 2: hundreds; blank if hundreds==0.
  - Index 3: always blank.
  - Blank = 7'b1111111.
- Encoding, 0-9 (gfedcba, active low):
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000, 4: 0011001
  - 5: 0010010, 6: 0000010, 7: 1111000, 8: 0000000, 9: 0010000
  - Nibble values > 9 are unreachable; encode them as blank.

Test Plan (SAMPLE_PERIOD=16, REFRESH_PERIOD=4):
- Release reset, i_value=8'd255 -> first o_bcd_valid pulse exactly 10 cycles after the first tick (cycle 15). o_bcd=12'h255. Over a full scan, anodes 1110/1101/1011/0111 show 0010010, 0010010, 0100100, 1111111.
- i_value=8'd7 -> o_bcd=12'h007. Digit0=1111000; digits 1, 2, 3 blank.
- i_value=8'd105 -> o_bcd=12'h105. Digit1 shows 1000000 (interior zero not blanked); digit2=1111001.
- i_value=8'd0 -> o_bcd=12'h000. Only digit0 lit, 1000000. o_bcd_valid pulses once per 16 cycles, each 1 cycle wide.
- Load 8'd200, change i_value to 8'd50 on the next cycle -> o_bcd=12'h200. The following sample yields 12'h050 (digit2 blank, digit1=0010010).
- Assert i_reset for 1 cycle during CONVERT (4th iteration) -> no valid pulse for that sample, o_bcd=12'h000, o_anode=1110. The next valid pulse is 10 cycles after the first post-reset tick.
